// File: rtl/cache_stage_pkg.sv
// Shared definitions for the memory-access cache stage: load/store op codes,
// FSM state encoding and the layout of the stage input register.
package cache_stage_pkg;

  localparam logic [1:0] LDST_NONE = 2'b00;
  localparam logic [1:0] LDST_ST   = 2'b01;
  localparam logic [1:0] LDST_LD   = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ldst;
    logic [2:0]  dest;
    logic        we;
    logic [1:0]  bp;
  } stage_reg_t;

endpackage

// File: rtl/cache_stage_if.sv
// Word-wide memory request/acknowledge bus between the cache stage (master)
// and backing memory (slave).
interface cache_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/cache_line_array.sv
// Direct-mapped tag/valid/data storage: one combinational read port on the current
// index, one word write port, and line-fill invalidate/validate controls.
module cache_line_array #(
  parameter int LINES = 4,
  parameter int WORDS = 4,
  parameter int TAG_W = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic [$clog2(WORDS)-1:0] off,
  input  logic [TAG_W-1:0]         tag,
  output logic [15:0]              rd_data,
  output logic                     hit,
  input  logic                     word_we,
  input  logic [$clog2(WORDS)-1:0] word_off,
  input  logic [15:0]              word_data,
  input  logic                     inval,
  input  logic                     fill_done
);

  logic [LINES-1:0][WORDS-1:0][15:0] data_q, data_d;
  logic [LINES-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [LINES-1:0]                  valid_q, valid_d;

  assign rd_data = data_q[idx][off];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (word_we) data_d[idx][word_off] = word_data;
    if (inval) valid_d[idx] = 1'b0;
    if (fill_done) begin
      tag_d[idx]   = tag;
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cache_stage.sv
// Memory-access pipeline stage: direct-mapped write-through, no-write-allocate data cache
// with a req/ack memory FSM for line refills and store write-through.
//
// state    | meaning
// IDLE     | lookup on registered op; hits and non-memory ops pass straight through
// REFILL   | fetching WORDS words of the missed line, one per mem_ack
// WRITE    | store written through to memory, waiting for mem_ack
// DONE     | store retired; waits for the input register to take the next op
module cache_stage
  import cache_stage_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_cache,
  input  logic [15:0]   tlblookup_result,
  input  logic [15:0]   dataReg,
  input  logic [1:0]    ldSt_enable,
  input  logic [2:0]    destReg_addr_input,
  input  logic          we_input,
  input  logic [1:0]    bp_input,
  output logic [15:0]   cache_result,
  output logic [2:0]    destReg_addr_output,
  output logic          we_output,
  output logic [1:0]    bp_output,
  output logic          stall,
  cache_stage_if.master mem
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 15 - IDX_W - OFF_W;

  stage_reg_t       in_q, in_d;
  logic [1:0]       state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off, word_off;
  logic [TAG_W-1:0] tag;
  logic [15:0]      rd_data, word_data;
  logic             hit, is_ld, is_st, word_we, inval, fill_done;

  assign off   = in_q.addr[OFF_W:1];
  assign idx   = in_q.addr[OFF_W+IDX_W:OFF_W+1];
  assign tag   = in_q.addr[15:OFF_W+IDX_W+1];
  assign is_ld = (in_q.ldst == LDST_LD);
  assign is_st = (in_q.ldst == LDST_ST);

  always_comb begin
    in_d = in_q;
    if (enable_cache && !stall)
      in_d = '{addr: tlblookup_result, wdata: dataReg, ldst: ldSt_enable,
               dest: destReg_addr_input, we: we_input, bp: bp_input};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    word_we       = 1'b0;
    word_off      = off;
    word_data     = in_q.wdata;
    inval         = 1'b0;
    fill_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_ld && !hit) begin
          stall   = 1'b1;
          inval   = 1'b1;
          cnt_d   = '0;
          state_d = S_REFILL;
        end else if (is_st) begin
          stall   = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_REFILL: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {tag, idx, cnt_q, 1'b0};
        if (mem.mem_ack) begin
          word_we   = 1'b1;
          word_off  = cnt_q;
          word_data = mem.mem_rdata;
          cnt_d     = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {in_q.addr[15:1], 1'b0};
        mem.mem_wdata = in_q.wdata;
        // Write-through updates the cached copy only on a hit: no allocation on store miss.
        if (mem.mem_ack) begin
          word_we = hit;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (enable_cache) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      in_q    <= in_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  cache_line_array #(.LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)) u_lines (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .off       (off),
    .tag       (tag),
    .rd_data   (rd_data),
    .hit       (hit),
    .word_we   (word_we),
    .word_off  (word_off),
    .word_data (word_data),
    .inval     (inval),
    .fill_done (fill_done)
  );

  assign cache_result        = is_ld ? rd_data : in_q.addr;
  assign destReg_addr_output = in_q.dest;
  assign bp_output           = in_q.bp;
  assign we_output           = in_q.we & ~stall;

endmodule

// File: tb/tb_cache_stage.sv
// Directed self-checking bench for cache_stage: refill, hits, write-through stores,
// store miss without allocation, passthrough ops, and reset during refill.
module tb_cache_stage;
  import cache_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_cache;
  logic [15:0] tlblookup_result, dataReg;
  logic [1:0]  ldSt_enable;
  logic [2:0]  destReg_addr_input;
  logic        we_input;
  logic [1:0]  bp_input;
  logic [15:0] cache_result;
  logic [2:0]  destReg_addr_output;
  logic        we_output;
  logic [1:0]  bp_output;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  cache_stage_if mem_if ();

  cache_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .enable_cache        (enable_cache),
    .tlblookup_result    (tlblookup_result),
    .dataReg             (dataReg),
    .ldSt_enable         (ldSt_enable),
    .destReg_addr_input  (destReg_addr_input),
    .we_input            (we_input),
    .bp_input            (bp_input),
    .cache_result        (cache_result),
    .destReg_addr_output (destReg_addr_output),
    .we_output           (we_output),
    .bp_output           (bp_output),
    .stall               (stall),
    .mem                 (mem_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] a, input logic [15:0] d, input logic [1:0] op,
                        input logic [2:0] dst, input logic we, input logic [1:0] bp);
    tlblookup_result   = a;
    dataReg            = d;
    ldSt_enable        = op;
    destReg_addr_input = dst;
    we_input           = we;
    bp_input           = bp;
  endtask

  // Acks the four words of a line refill, checking each request address.
  task automatic refill(input string tag, input logic [15:0] base, input logic [15:0] dbase);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_req"}, {15'd0, mem_if.mem_req}, 16'd1);
      check({tag, "_we"}, {15'd0, mem_if.mem_we}, 16'd0);
      check({tag, "_addr"}, mem_if.mem_addr, base + 16'(2 * i));
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = dbase + 16'(i);
      tick();
      mem_if.mem_ack   = 1'b0;
    end
  endtask

  initial begin
    reset            = 1'b0;
    enable_cache     = 1'b0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0;
    set_in(16'h0, 16'h0, LDST_NONE, 3'd0, 1'b0, 2'b00);
    repeat (2) tick();
    check("rst_result", cache_result, 16'h0);
    check("rst_stall", {15'd0, stall}, 16'd0);
    check("rst_req", {15'd0, mem_if.mem_req}, 16'd0);
    check("rst_we", {15'd0, we_output}, 16'd0);
    reset        = 1'b1;
    enable_cache = 1'b1;

    // 1: load miss with full refill
    set_in(16'h0010, 16'h0, LDST_LD, 3'd3, 1'b1, 2'b01);
    tick();
    check("t1_miss_stall", {15'd0, stall}, 16'd1);
    check("t1_miss_req", {15'd0, mem_if.mem_req}, 16'd0);
    check("t1_miss_we", {15'd0, we_output}, 16'd0);
    tick();
    refill("t1", 16'h0010, 16'h00A0);
    check("t1_result", cache_result, 16'h00A0);
    check("t1_stall", {15'd0, stall}, 16'd0);
    check("t1_we", {15'd0, we_output}, 16'd1);
    check("t1_dest", {13'd0, destReg_addr_output}, 16'd3);
    check("t1_bp", {14'd0, bp_output}, 16'd1);
    check("t1_req", {15'd0, mem_if.mem_req}, 16'd0);

    // 2: same-cycle hit
    set_in(16'h0014, 16'h0, LDST_LD, 3'd4, 1'b1, 2'b00);
    tick();
    check("t2_result", cache_result, 16'h00A2);
    check("t2_stall", {15'd0, stall}, 16'd0);
    check("t2_req", {15'd0, mem_if.mem_req}, 16'd0);

    // 3: store hit with delayed ack, then load of the stored word
    set_in(16'h0012, 16'h5555, LDST_ST, 3'd0, 1'b0, 2'b00);
    tick();
    check("t3_st_stall", {15'd0, stall}, 16'd1);
    check("t3_st_req0", {15'd0, mem_if.mem_req}, 16'd0);
    set_in(16'h0012, 16'h0000, LDST_LD, 3'd2, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_wr_req", {15'd0, mem_if.mem_req}, 16'd1);
      check("t3_wr_we", {15'd0, mem_if.mem_we}, 16'd1);
      check("t3_wr_addr", mem_if.mem_addr, 16'h0012);
      check("t3_wr_data", mem_if.mem_wdata, 16'h5555);
      check("t3_wr_stall", {15'd0, stall}, 16'd1);
    end
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    check("t3_done_stall", {15'd0, stall}, 16'd0);
    check("t3_done_req", {15'd0, mem_if.mem_req}, 16'd0);
    check("t3_done_we", {15'd0, we_output}, 16'd0);
    tick();
    check("t3_ld_result", cache_result, 16'h5555);
    check("t3_ld_stall", {15'd0, stall}, 16'd0);
    check("t3_ld_req", {15'd0, mem_if.mem_req}, 16'd0);
    check("t3_ld_we", {15'd0, we_output}, 16'd1);

    // 4: store miss writes memory only; following load still misses
    set_in(16'h0100, 16'hBEEF, LDST_ST, 3'd0, 1'b0, 2'b00);
    tick();
    check("t4_st_stall", {15'd0, stall}, 16'd1);
    set_in(16'h0100, 16'h0000, LDST_LD, 3'd6, 1'b1, 2'b00);
    tick();
    check("t4_wr_addr", mem_if.mem_addr, 16'h0100);
    check("t4_wr_data", mem_if.mem_wdata, 16'hBEEF);
    check("t4_wr_we", {15'd0, mem_if.mem_we}, 16'd1);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    check("t4_done_stall", {15'd0, stall}, 16'd0);
    tick();
    check("t4_ld_miss", {15'd0, stall}, 16'd1);
    tick();
    refill("t4", 16'h0100, 16'h00B0);
    check("t4_result", cache_result, 16'h00B0);
    check("t4_stall", {15'd0, stall}, 16'd0);
    check("t4_dest", {13'd0, destReg_addr_output}, 16'd6);

    // 5: non-memory ops pass through
    set_in(16'h1234, 16'h0, LDST_NONE, 3'd5, 1'b1, 2'b10);
    tick();
    check("t5_result", cache_result, 16'h1234);
    check("t5_stall", {15'd0, stall}, 16'd0);
    check("t5_we", {15'd0, we_output}, 16'd1);
    check("t5_dest", {13'd0, destReg_addr_output}, 16'd5);
    check("t5_bp", {14'd0, bp_output}, 16'd2);
    check("t5_req", {15'd0, mem_if.mem_req}, 16'd0);
    set_in(16'h4321, 16'h9999, 2'b11, 3'd7, 1'b1, 2'b11);
    tick();
    check("t5b_result", cache_result, 16'h4321);
    check("t5b_stall", {15'd0, stall}, 16'd0);
    check("t5b_req", {15'd0, mem_if.mem_req}, 16'd0);
    set_in(16'h0016, 16'h0, LDST_LD, 3'd1, 1'b1, 2'b00);
    tick();
    check("t5c_hit", cache_result, 16'h00A3);
    check("t5c_stall", {15'd0, stall}, 16'd0);

    // 6: conflicting refill aborted by reset (with ack held high)
    set_in(16'h0030, 16'h0, LDST_LD, 3'd1, 1'b1, 2'b00);
    tick();
    check("t6_miss", {15'd0, stall}, 16'd1);
    tick();
    check("t6_addr0", mem_if.mem_addr, 16'h0030);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'h00C0;
    tick();
    check("t6_addr1", mem_if.mem_addr, 16'h0032);
    mem_if.mem_rdata = 16'h00C1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_req", {15'd0, mem_if.mem_req}, 16'd0);
    check("t6_rst_stall", {15'd0, stall}, 16'd0);
    check("t6_rst_result", cache_result, 16'h0);
    check("t6_rst_we", {15'd0, we_output}, 16'd0);
    check("t6_rst_dest", {13'd0, destReg_addr_output}, 16'd0);
    mem_if.mem_ack = 1'b0;
    tick();
    reset = 1'b1;
    set_in(16'h0010, 16'h0, LDST_LD, 3'd1, 1'b1, 2'b00);
    tick();
    check("t6_reload_miss", {15'd0, stall}, 16'd1);
    check("t6_reload_we", {15'd0, we_output}, 16'd0);
    tick();
    check("t6_reload_req", {15'd0, mem_if.mem_req}, 16'd1);
    check("t6_reload_addr", mem_if.mem_addr, 16'h0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
